// File: rtl/pipe_pkg.sv
// ----------------------------------------------------------------------------
// pipe_pkg
//   Shared types for the pipeline skid stage.
//   pipe_state_t : occupancy state of the two-entry stage (EMPTY/ONE/FULL);
//                  the encoding equals the number of beats held.
//   OCC_W        : width of the occupancy output.
// ----------------------------------------------------------------------------
package pipe_pkg;

    localparam int unsigned OCC_W = 2;

    typedef enum logic [OCC_W-1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/sat_cnt.sv
// ----------------------------------------------------------------------------
// sat_cnt
//   Saturating up-counter with synchronous clear.
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-high reset (count -> 0)
//   clr   : synchronous clear, wins over inc
//   inc   : add one this cycle unless already at all-ones
//   q     : current count
// ----------------------------------------------------------------------------
module sat_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// ----------------------------------------------------------------------------
// pipe_skid_stage
//   Pipeline stage register with a 2-entry skid buffer, valid/ready handshake,
//   synchronous flush and a saturating back-pressure counter.
//   clk_i        : clock, rising edge
//   rst_i        : asynchronous active-high reset
//   flush_i      : synchronous flush, drops held and incoming beats
//   in_valid_i   : upstream beat valid
//   in_ready_o   : stage can accept (registered)
//   in_ctrl_i    : upstream control field
//   in_data_i    : upstream data field
//   out_valid_o  : downstream beat valid (registered)
//   out_ready_i  : downstream accepts
//   out_ctrl_o   : control field, zero whenever out_valid_o is low
//   out_data_o   : data field, holds last value when invalid
//   occupancy_o  : beats held (0..2)
//   cnt_clr_i    : synchronous clear of the stall counter
//   stall_cnt_o  : saturating count of out_valid_o & ~out_ready_i cycles
// ----------------------------------------------------------------------------
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = 12,
    parameter int unsigned DATA_W = 176,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [OCC_W-1:0]  occupancy_o,
    input  logic              cnt_clr_i,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    pipe_state_t       state;
    logic              ready_q;
    logic              valid_q;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    logic in_fire;
    logic out_fire;

    assign in_fire  = in_valid_i & ready_q;
    assign out_fire = valid_q & out_ready_i;

    // ready_q/valid_q are written alongside state so the handshake outputs
    // come straight from flops; main_ctrl is zeroed on every entry to EMPTY,
    // which keeps out_ctrl_o at zero while invalid without output gating.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= EMPTY;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            main_ctrl <= '0;
            main_data <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else if (flush_i) begin
            state     <= EMPTY;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            main_ctrl <= '0;
            skid_ctrl <= '0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_ctrl <= in_ctrl_i;
                        main_data <= in_data_i;
                        state     <= ONE;
                        valid_q   <= 1'b1;
                        ready_q   <= 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_ctrl <= in_ctrl_i;
                        main_data <= in_data_i;
                    end else if (in_fire) begin
                        skid_ctrl <= in_ctrl_i;
                        skid_data <= in_data_i;
                        state     <= FULL;
                        ready_q   <= 1'b0;
                    end else if (out_fire) begin
                        main_ctrl <= '0;
                        state     <= EMPTY;
                        valid_q   <= 1'b0;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_ctrl <= skid_ctrl;
                        main_data <= skid_data;
                        skid_ctrl <= '0;
                        state     <= ONE;
                        ready_q   <= 1'b1;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    ready_q   <= 1'b1;
                    valid_q   <= 1'b0;
                    main_ctrl <= '0;
                    skid_ctrl <= '0;
                end
            endcase
        end
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = valid_q;
    assign out_ctrl_o  = main_ctrl;
    assign out_data_o  = main_data;
    assign occupancy_o = OCC_W'(state);

    sat_cnt #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr   (cnt_clr_i),
        .inc   (valid_q & ~out_ready_i),
        .q     (stall_cnt_o)
    );

endmodule

// File: tb/tb_pipe_skid_stage.sv
module tb_pipe_skid_stage;

    localparam int unsigned CTRL_W = 12;
    localparam int unsigned DATA_W = 176;
    localparam int unsigned CNT_W  = 16;

    typedef struct packed {
        logic [CTRL_W-1:0] c;
        logic [DATA_W-1:0] d;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              flush_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [CTRL_W-1:0] in_ctrl_i;
    logic [DATA_W-1:0] in_data_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [CTRL_W-1:0] out_ctrl_o;
    logic [DATA_W-1:0] out_data_o;
    logic [1:0]        occupancy_o;
    logic              cnt_clr_i;
    logic [CNT_W-1:0]  stall_cnt_o;

    pipe_skid_stage #(
        .CTRL_W(CTRL_W),
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_ctrl_i   (in_ctrl_i),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_ctrl_o  (out_ctrl_o),
        .out_data_o  (out_data_o),
        .occupancy_o (occupancy_o),
        .cnt_clr_i   (cnt_clr_i),
        .stall_cnt_o (stall_cnt_o)
    );

    always #5 clk = ~clk;

    int    total = 0;
    int    bad   = 0;
    beat_t exp_q[$];
    int    held     = 0;   // model occupancy during the current cycle
    int    held_nxt = 0;
    int    stall_m  = 0;   // model stall counter
    bit    run      = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; the model decides acceptance and pushes the
    // expected beat into the scoreboard.
    task automatic step(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                        input logic ordy, input logic fl, input logic clr, output logic acc);
        logic ofire;
        @(posedge clk);
        #1;
        held        = held_nxt;
        in_valid_i  = v;
        in_ctrl_i   = c;
        in_data_i   = d;
        out_ready_i = ordy;
        flush_i     = fl;
        cnt_clr_i   = clr;
        acc   = v && !fl && (held != 2);
        ofire = (held != 0) && ordy;
        if (acc) exp_q.push_back('{c: c, d: d});
        if (fl) held_nxt = 0;
        else    held_nxt = held - int'(ofire) + int'(acc);
    endtask

    task automatic idle(input logic ordy, input int n);
        logic a;
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, ordy, 1'b0, 1'b0, a);
    endtask

    task automatic reset_mid();
        @(posedge clk);
        #1;
        in_valid_i  = 1'b0;
        flush_i     = 1'b0;
        cnt_clr_i   = 1'b0;
        out_ready_i = 1'b0;
        rst_i = 1'b1;
        #1;
        check("rst_out_valid", 256'(out_valid_o), 256'(0));
        check("rst_in_ready",  256'(in_ready_o),  256'(1));
        check("rst_occ",       256'(occupancy_o), 256'(0));
        check("rst_out_ctrl",  256'(out_ctrl_o),  256'(0));
        check("rst_out_data",  256'(out_data_o),  256'(0));
        check("rst_stall",     256'(stall_cnt_o), 256'(0));
        exp_q.delete();
        held = 0; held_nxt = 0; stall_m = 0;
        #1;
        rst_i = 1'b0;
    endtask

    // Monitor: compares every cycle against the model, pops on output fire.
    initial begin
        forever begin
            @(negedge clk);
            if (run && !rst_i) begin
                check("occupancy", 256'(occupancy_o), 256'(held));
                check("in_ready",  256'(in_ready_o),  256'(held != 2));
                check("out_valid", 256'(out_valid_o), 256'(held != 0));
                check("stall_cnt", 256'(stall_cnt_o), 256'(stall_m));
                if (held != 0) begin
                    if (exp_q.size() == 0) begin
                        check("scoreboard_underflow", 256'(1), 256'(0));
                    end else begin
                        check("out_ctrl", 256'(out_ctrl_o), 256'(exp_q[0].c));
                        check("out_data", 256'(out_data_o), 256'(exp_q[0].d));
                        if (out_ready_i) void'(exp_q.pop_front());
                    end
                end else begin
                    check("ctrl_zero_idle", 256'(out_ctrl_o), 256'(0));
                end
                if (flush_i) exp_q.delete();
                if (cnt_clr_i) stall_m = 0;
                else if ((held != 0) && !out_ready_i && (stall_m != 65535)) stall_m++;
            end
        end
    end

    initial begin
        logic a;
        int   seq;
        rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; in_ctrl_i = '0;
        in_data_i = '0; out_ready_i = 1'b0; cnt_clr_i = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("init_in_ready",  256'(in_ready_o),  256'(1));
        check("init_out_valid", 256'(out_valid_o), 256'(0));
        check("init_occ",       256'(occupancy_o), 256'(0));
        check("init_stall",     256'(stall_cnt_o), 256'(0));
        rst_i = 1'b0;
        run = 1;

        // streaming with downstream always ready
        for (int i = 0; i < 8; i++)
            step(1'b1, 12'(i + 1), {8'hA0, 168'(i * 3 + 7)}, 1'b1, 1'b0, 1'b0, a);
        idle(1'b1, 2);

        // back-pressure: 0x001, 0x002 absorbed, 0x003 waits
        step(1'b1, 12'h001, 176'h11, 1'b0, 1'b0, 1'b0, a);
        step(1'b1, 12'h002, 176'h22, 1'b0, 1'b0, 1'b0, a);
        step(1'b1, 12'h003, 176'h33, 1'b0, 1'b0, 1'b0, a);
        check("third_rejected_full", 256'(a), 256'(0));
        a = 1'b0;
        for (int i = 0; i < 10 && !a; i++)
            step(1'b1, 12'h003, 176'h33, 1'b1, 1'b0, 1'b0, a);
        check("third_eventually_accepted", 256'(a), 256'(1));
        idle(1'b1, 3);

        // flush while FULL with a beat offered
        step(1'b1, 12'h010, 176'h100, 1'b0, 1'b0, 1'b0, a);
        step(1'b1, 12'h020, 176'h200, 1'b0, 1'b0, 1'b0, a);
        step(1'b1, 12'h7FF, 176'hDEAD, 1'b0, 1'b1, 1'b0, a);
        idle(1'b1, 3);

        // stall counter saturation and clear
        step(1'b1, 12'h0AA, 176'hBEEF, 1'b0, 1'b0, 1'b0, a);
        idle(1'b0, 70000);
        #1;
        check("stall_saturated", 256'(stall_cnt_o), 256'(16'hFFFF));
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, a);
        idle(1'b1, 2);
        check("stall_cleared", 256'(stall_cnt_o), 256'(0));

        // async reset while FULL, then restart
        step(1'b1, 12'h051, 176'h51, 1'b0, 1'b0, 1'b0, a);
        step(1'b1, 12'h052, 176'h52, 1'b0, 1'b0, 1'b0, a);
        idle(1'b0, 1);
        reset_mid();
        for (int i = 0; i < 4; i++)
            step(1'b1, 12'(12'h060 + i), 176'(i + 100), 1'b1, 1'b0, 1'b0, a);
        idle(1'b1, 3);

        // random valid/ready with rare flush
        seq = 0;
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)), 12'($urandom), {16'hC0DE, 160'(seq)},
                 1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0), 1'b0, a);
            if (a) seq++;
        end
        idle(1'b1, 4);
        check("drained", 256'(exp_q.size()), 256'(0));

        run = 0;
        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
